// File: rtl/servo_pwm_generator_pkg.sv
// Shared servo timing constants and position type for the servo PWM channel blocks.
package servo_pwm_generator_pkg;
  localparam int SERVO_TICK_HZ    = 128000;
  localparam int PERIOD_TICKS     = 2560;
  localparam int MIN_PULSE_TICKS  = 128;
  localparam int POSITION_WIDTH   = 8;
  localparam int COUNTER_WIDTH    = 12;
  localparam int DEFAULT_POSITION = 128;

  typedef logic [POSITION_WIDTH-1:0] position_t;
endpackage

// File: rtl/servo_pwm_generator_tick_edge_detect.sv
// Rising-edge detector turning the divided clock into a one-system-clock tick pulse.
module servo_tick_edge_detect
  import servo_pwm_generator_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tick_in,
  output logic tick_pulse
);

  logic tick_prev_q;
  logic tick_prev_d;

  always_comb tick_prev_d = tick_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_prev_q <= 1'b0;
    else        tick_prev_q <= tick_prev_d;
  end

  assign tick_pulse = tick_in & ~tick_prev_q;

endmodule

// File: rtl/servo_pwm_generator.sv
// Single-channel servo PWM: 20 ms frame, pulse width from a position applied only on frame boundaries.
module servo_pwm_generator
  import servo_pwm_generator_pkg::*;
#(
  parameter int PERIOD_TICKS     = servo_pwm_generator_pkg::PERIOD_TICKS,
  parameter int MIN_PULSE_TICKS  = servo_pwm_generator_pkg::MIN_PULSE_TICKS,
  parameter int POSITION_WIDTH   = servo_pwm_generator_pkg::POSITION_WIDTH,
  parameter int COUNTER_WIDTH    = servo_pwm_generator_pkg::COUNTER_WIDTH,
  parameter int DEFAULT_POSITION = servo_pwm_generator_pkg::DEFAULT_POSITION
) (
  input  logic                      SPG_CLOCK_IN,
  input  logic                      SPG_RESET,
  input  logic                      SPG_TICK_IN,
  input  logic                      SPG_ENABLE,
  input  logic [POSITION_WIDTH-1:0] SPG_POSITION,
  input  logic                      SPG_POSITION_VALID,
  output logic                      SPG_POSITION_READY,
  output logic [POSITION_WIDTH-1:0] SPG_ACTIVE_POSITION,
  output logic                      SPG_FRAME_START,
  output logic                      SPG_PWM_OUT
);

  localparam int CMP_W = COUNTER_WIDTH + 1;

  logic                      tick;
  logic                      accept;
  logic                      boundary;
  logic [COUNTER_WIDTH-1:0]  counter_q, counter_d;
  logic                      idle_q, idle_d;
  logic                      pending_full_q, pending_full_d;
  logic [POSITION_WIDTH-1:0] pending_q, pending_d;
  logic [POSITION_WIDTH-1:0] active_q, active_d;
  logic                      frame_start_q, frame_start_d;
  logic                      pwm_q, pwm_d;
  logic [CMP_W-1:0]          pulse_limit;

  servo_tick_edge_detect u_tick_edge (
    .clk       (SPG_CLOCK_IN),
    .rst_n     (SPG_RESET),
    .tick_in   (SPG_TICK_IN),
    .tick_pulse(tick)
  );

  assign accept   = SPG_POSITION_VALID & ~pending_full_q;
  assign boundary = tick & SPG_ENABLE &
                    (idle_q | (counter_q == COUNTER_WIDTH'(PERIOD_TICKS - 1)));

  always_comb begin
    counter_d      = counter_q;
    idle_d         = idle_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    active_d       = active_q;
    frame_start_d  = 1'b0;

    if (!SPG_ENABLE) begin
      counter_d = '0;
      idle_d    = 1'b1;
    end else if (boundary) begin
      counter_d     = '0;
      idle_d        = 1'b0;
      frame_start_d = 1'b1;
      if (pending_full_q) begin
        active_d       = pending_q;
        pending_full_d = 1'b0;
      end
    end else if (tick) begin
      counter_d = counter_q + 1'b1;
    end

    // Accept and boundary-apply are exclusive: accept needs pending empty, apply needs it full.
    if (accept) begin
      pending_d      = SPG_POSITION;
      pending_full_d = 1'b1;
    end

    pulse_limit = CMP_W'(MIN_PULSE_TICKS) + CMP_W'(active_d);
    pwm_d       = SPG_ENABLE & ~idle_d & ({1'b0, counter_d} < pulse_limit);
  end

  always_ff @(posedge SPG_CLOCK_IN or negedge SPG_RESET) begin
    if (!SPG_RESET) begin
      counter_q      <= '0;
      idle_q         <= 1'b1;
      pending_full_q <= 1'b0;
      active_q       <= POSITION_WIDTH'(DEFAULT_POSITION);
      frame_start_q  <= 1'b0;
      pwm_q          <= 1'b0;
    end else begin
      counter_q      <= counter_d;
      idle_q         <= idle_d;
      pending_full_q <= pending_full_d;
      active_q       <= active_d;
      frame_start_q  <= frame_start_d;
      pwm_q          <= pwm_d;
    end
  end

  // Pending data is only meaningful while pending_full is set, so it needs no reset.
  always_ff @(posedge SPG_CLOCK_IN) begin
    pending_q <= pending_d;
  end

  assign SPG_POSITION_READY  = ~pending_full_q;
  assign SPG_ACTIVE_POSITION = active_q;
  assign SPG_FRAME_START     = frame_start_q;
  assign SPG_PWM_OUT         = pwm_q;

endmodule

// File: tb/tb_servo_pwm_generator.sv
// Directed bench for servo_pwm_generator: frame/pulse lengths, handshake timing, enable, reset, held tick.
module tb_servo_pwm_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_in;
  logic       enable;
  logic [7:0] pos;
  logic       valid;
  logic       ready;
  logic [7:0] active;
  logic       frame_start;
  logic       pwm;

  int n_cmp  = 0;
  int n_fail = 0;

  int tick_half   = 4;
  bit tick_freeze = 1'b0;
  int ph_cnt      = 0;

  int hi_cnt   = 0;
  int len_cnt  = 0;
  int last_hi  = 0;
  int last_len = 0;

  servo_pwm_generator dut (
    .SPG_CLOCK_IN       (clk),
    .SPG_RESET          (rst_n),
    .SPG_TICK_IN        (tick_in),
    .SPG_ENABLE         (enable),
    .SPG_POSITION       (pos),
    .SPG_POSITION_VALID (valid),
    .SPG_POSITION_READY (ready),
    .SPG_ACTIVE_POSITION(active),
    .SPG_FRAME_START    (frame_start),
    .SPG_PWM_OUT        (pwm)
  );

  always #5 clk = ~clk;

  // Divided-clock source: square wave toggling every tick_half system clocks, freezable.
  initial begin
    tick_in = 1'b0;
    forever begin
      @(negedge clk);
      if (!tick_freeze) begin
        if (ph_cnt >= tick_half - 1) begin
          tick_in = ~tick_in;
          ph_cnt  = 0;
        end else begin
          ph_cnt++;
        end
      end
    end
  end

  // Per-frame measurement window: from one FRAME_START cycle up to the next.
  always @(negedge clk) begin
    if (frame_start) begin
      last_hi  <= hi_cnt;
      last_len <= len_cnt;
      hi_cnt   <= pwm ? 1 : 0;
      len_cnt  <= 1;
    end else begin
      hi_cnt  <= hi_cnt + (pwm ? 1 : 0);
      len_cnt <= len_cnt + 1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(input string tag, input int max_clk);
    bit seen = 1'b0;
    for (int i = 0; i < max_clk && !seen; i++) begin
      @(negedge clk);
      if (frame_start) seen = 1'b1;
    end
    #1;
    check({tag, "_frame_start"}, int'(seen), 1);
  endtask

  task automatic send(input logic [7:0] p, input int max_clk);
    bit done = 1'b0;
    pos   = p;
    valid = 1'b1;
    for (int i = 0; i < max_clk && !done; i++) begin
      if (ready) done = 1'b1;
      @(negedge clk);
      #1;
    end
    valid = 1'b0;
    check("send_accepted", int'(done), 1);
  endtask

  initial begin
    bit bad;

    // Reset values
    rst_n  = 1'b0;
    enable = 1'b1;
    valid  = 1'b0;
    pos    = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pwm", int'(pwm), 0);
    check("rst_ready", int'(ready), 1);
    check("rst_active", int'(active), 128);
    check("rst_frame_start", int'(frame_start), 0);

    // Test 1: default position, tick period 8 clocks
    rst_n = 1'b1;
    wait_frame("t1_first", 20);
    check("t1_pwm_rise", int'(pwm), 1);
    wait_frame("t1_second", 21000);
    check("t1_high_clocks", last_hi, 256 * 8);
    check("t1_frame_clocks", last_len, 2560 * 8);
    check("t1_active", int'(active), 128);
    check("t1_ready", int'(ready), 1);
    tick_half = 1;

    // Test 2: accept 0, then hold 255 until the next boundary
    repeat (100) @(negedge clk);
    #1;
    send(8'd0, 10);
    check("t2_ready_low", int'(ready), 0);
    pos   = 8'd255;
    valid = 1'b1;
    @(negedge clk);
    #1;
    check("t2_ready_held", int'(ready), 0);
    check("t2_active_old", int'(active), 128);
    wait_frame("t2_f3", 6000);
    check("t2_active_0", int'(active), 0);
    check("t2_ready_boundary", int'(ready), 1);
    @(negedge clk);
    #1;
    valid = 1'b0;
    check("t2_255_accepted", int'(ready), 0);
    wait_frame("t2_f4", 6000);
    check("t2_pulse_128", last_hi, 128 * 2);
    check("t2_frame_len", last_len, 5120);
    check("t2_active_255", int'(active), 255);
    wait_frame("t2_f5", 6000);
    check("t2_pulse_383", last_hi, 383 * 2);

    // Test 3: VALID with 10 exactly on the boundary clock
    repeat (5119) @(negedge clk);
    #1;
    pos   = 8'd10;
    valid = 1'b1;
    wait_frame("t3_f6", 1);
    valid = 1'b0;
    check("t3_active_old", int'(active), 255);
    check("t3_pending", int'(ready), 0);
    check("t3_f5_pulse", last_hi, 383 * 2);
    wait_frame("t3_f7", 6000);
    check("t3_f6_pulse_old", last_hi, 383 * 2);
    check("t3_active_10", int'(active), 10);
    check("t3_ready", int'(ready), 1);
    wait_frame("t3_f8", 6000);
    check("t3_pulse_138", last_hi, 138 * 2);
    check("t3_frame_len", last_len, 5120);

    // Test 4: drop enable at tick 100, then re-enable
    repeat (200) @(negedge clk);
    #1;
    check("t4_pwm_before", int'(pwm), 1);
    enable = 1'b0;
    @(negedge clk);
    #1;
    check("t4_pwm_off", int'(pwm), 0);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (pwm !== 1'b0 || frame_start !== 1'b0) bad = 1'b1;
    end
    check("t4_idle_quiet", int'(bad), 0);
    enable = 1'b1;
    wait_frame("t4_restart", 4);
    check("t4_pwm_restart", int'(pwm), 1);
    wait_frame("t4_full", 6000);
    check("t4_full_pulse", last_hi, 138 * 2);
    check("t4_full_len", last_len, 5120);

    // Test 5: asynchronous reset mid-pulse with a pending value
    repeat (50) @(negedge clk);
    #1;
    send(8'd77, 10);
    check("t5_pending", int'(ready), 0);
    check("t5_mid_pulse", int'(pwm), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_pwm", int'(pwm), 0);
    check("t5_rst_ready", int'(ready), 1);
    check("t5_rst_active", int'(active), 128);
    check("t5_rst_frame_start", int'(frame_start), 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    wait_frame("t5_resume", 6);
    check("t5_active_discard", int'(active), 128);
    check("t5_pwm_resume", int'(pwm), 1);

    // Test 6: hold the tick input high across the tick that sets counter to 255
    repeat (509) @(negedge clk);
    #1;
    tick_freeze = 1'b1;
    check("t6_tick_high", int'(tick_in), 1);
    bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      #1;
      if (pwm !== 1'b1 || frame_start !== 1'b0) bad = 1'b1;
    end
    check("t6_hold_stable", int'(bad), 0);
    tick_freeze = 1'b0;
    @(negedge clk);
    #1;
    check("t6_resume_low_phase", int'(pwm), 1);
    @(negedge clk);
    #1;
    check("t6_before_tick", int'(pwm), 1);
    @(negedge clk);
    #1;
    check("t6_pulse_end", int'(pwm), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
